// File: rtl/log2_block.sv
// log2_block: 3-stage fixed-point log2 of an unsigned Q16.16 sum-of-exponentials.
// Output is signed Q15.16 (1 sign, 15 int, 16 frac) for the base-2 exp stage.
//
// Ports:
//   clock_i           rising-edge clock
//   reset_i           synchronous active-high reset
//   log2_data_i       unsigned Q16.16 input word
//   log2_data_valid_i input qualifier (no backpressure)
//   log2_data_o       signed Q15.16 log2 result, holds while invalid
//   log2_data_valid_o output qualifier, 3 cycles after input
//   log2_zero_o       input was zero (result forced to most negative)
//   log2_last_o       final sample of each number_of_data vector
module log2_block #(
  parameter int data_size      = 32,
  parameter int lut_addr_bits  = 6,
  parameter int number_of_data = 10
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [data_size-1:0] log2_data_i,
  input  logic                 log2_data_valid_i,
  output logic [data_size-1:0] log2_data_o,
  output logic                 log2_data_valid_o,
  output logic                 log2_zero_o,
  output logic                 log2_last_o
);

  localparam int LUT_N = 1 << lut_addr_bits;
  localparam int CW =
    (number_of_data > 1) ? $clog2(number_of_data) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(number_of_data - 1);

  // Elaboration-time table: round(2^16 * (log2(1+m/N) - m/N)).
  // log2 of the mantissa is extracted bit by bit via repeated
  // squaring in Q2.62, with far more bits than the 16 kept.
  function automatic logic [15:0] lut_val(input int m);
    logic [127:0] y;
    logic [63:0]  r;
    logic [63:0]  d;
    y = 128'((1 << lut_addr_bits) + m) << (62 - lut_addr_bits);
    r = '0;
    for (int j = 0; j < 40; j++) begin
      y = (y * y) >> 62;
      r = r << 1;
      if (y[63]) begin
        r[0] = 1'b1;
        y    = y >> 1;
      end
    end
    d = r - (64'(m) << (40 - lut_addr_bits));
    return 16'((d + (64'd1 << 23)) >> 24);
  endfunction

  logic [15:0] lut [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam logic [15:0] LV = lut_val(gi);
    assign lut[gi] = LV;
  end

  // stage 1: leading-one detect
  logic                 s1_valid_q, s1_valid_d;
  logic [data_size-1:0] s1_x_q, s1_x_d;
  logic [4:0]           s1_p_q, s1_p_d;
  logic                 s1_zero_q, s1_zero_d;

  // stage 2: normalise
  logic                 s2_valid_q, s2_valid_d;
  logic [15:0]          s2_f_q, s2_f_d;
  logic [5:0]           s2_k_q, s2_k_d;
  logic                 s2_zero_q, s2_zero_d;

  // stage 3: correct, assemble, frame
  logic                 out_valid_q, out_valid_d;
  logic [data_size-1:0] out_data_q, out_data_d;
  logic                 out_zero_q, out_zero_d;
  logic                 out_last_q, out_last_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [4:0]           lod_p;
  logic [16:0]          sum;
  logic [15:0]          frac;

  always_comb begin
    lod_p = '0;
    for (int i = 0; i < data_size; i++) begin
      if (log2_data_i[i]) lod_p = 5'(i);
    end
    s1_valid_d = log2_data_valid_i;
    s1_x_d     = s1_x_q;
    s1_p_d     = s1_p_q;
    s1_zero_d  = s1_zero_q;
    if (log2_data_valid_i) begin
      s1_x_d    = log2_data_i;
      s1_p_d    = lod_p;
      s1_zero_d = (log2_data_i == '0);
    end
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_f_d     = s2_f_q;
    s2_k_d     = s2_k_q;
    s2_zero_d  = s2_zero_q;
    if (s1_valid_q) begin
      // MSB lands on bit 31; the 16 bits below it are the fraction
      s2_f_d    = 16'((s1_x_q << (5'd31 - s1_p_q)) >> 15);
      s2_k_d    = {1'b0, s1_p_q} - 6'd16;
      s2_zero_d = s1_zero_q;
    end
  end

  always_comb begin
    sum  = {1'b0, s2_f_q}
         + {1'b0, lut[s2_f_q[15 -: lut_addr_bits]]};
    frac = sum[16] ? 16'hFFFF : sum[15:0];

    out_valid_d = s2_valid_q;
    out_data_d  = out_data_q;
    out_zero_d  = 1'b0;
    out_last_d  = 1'b0;
    cnt_d       = cnt_q;
    if (s2_valid_q) begin
      out_zero_d = s2_zero_q;
      if (s2_zero_q) out_data_d = 32'h8000_0000;
      else out_data_d = {{10{s2_k_q[5]}}, s2_k_q, frac};
      if (cnt_q == CNT_MAX) begin
        out_last_d = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_p_q      <= '0;
      s1_zero_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_f_q      <= '0;
      s2_k_q      <= '0;
      s2_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_p_q      <= s1_p_d;
      s1_zero_q   <= s1_zero_d;
      s2_valid_q  <= s2_valid_d;
      s2_f_q      <= s2_f_d;
      s2_k_q      <= s2_k_d;
      s2_zero_q   <= s2_zero_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign log2_data_o       = out_data_q;
  assign log2_data_valid_o = out_valid_q;
  assign log2_zero_o       = out_zero_q;
  assign log2_last_o       = out_last_q;

endmodule

// File: tb/tb_log2_block.sv
// tb_log2_block: scoreboard bench for log2_block.
// Expected words come from spec constants or a real-math model.
module tb_log2_block;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [31:0] log2_data_i;
  logic        log2_data_valid_i;
  logic [31:0] log2_data_o;
  logic        log2_data_valid_o;
  logic        log2_zero_o;
  logic        log2_last_o;

  log2_block #(
    .data_size(32),
    .lut_addr_bits(6),
    .number_of_data(10)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .log2_data_i(log2_data_i),
    .log2_data_valid_i(log2_data_valid_i),
    .log2_data_o(log2_data_o),
    .log2_data_valid_o(log2_data_valid_o),
    .log2_zero_o(log2_zero_o),
    .log2_last_o(log2_last_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        l;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          tb_cnt = 0;
  int          last_seen = 0;
  logic [31:0] prev_d = '0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] x);
    int          p;
    int          m;
    int          lv;
    int          s;
    int          k;
    logic [31:0] n;
    logic [15:0] f;
    real         lr;
    if (x == 32'h0) return 32'h8000_0000;
    p = 0;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    n  = x << (31 - p);
    f  = n[30:15];
    m  = int'(f[15:10]);
    lr = 65536.0 * ($ln(1.0 + m / 64.0) / $ln(2.0) - m / 64.0);
    lv = $rtoi(lr + 0.5);
    s  = int'(f) + lv;
    if (s > 65535) s = 65535;
    k  = p - 16;
    return {k[15:0], s[15:0]};
  endfunction

  task automatic send(input logic [31:0] x, input logic [31:0] ed,
                      input logic ez);
    exp_t e;
    log2_data_i       = x;
    log2_data_valid_i = 1'b1;
    e.d = ed;
    e.z = ez;
    e.l = (tb_cnt == 9);
    e.c = cyc;
    tb_cnt = (tb_cnt == 9) ? 0 : tb_cnt + 1;
    exp_q.push_back(e);
    @(posedge clock_i);
    #1;
  endtask

  task automatic sendm(input logic [31:0] x);
    send(x, model(x), x == 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      log2_data_i       = $urandom;
      log2_data_valid_i = 1'b0;
      @(posedge clock_i);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_i           = 1'b1;
    log2_data_valid_i = 1'b0;
    exp_q.delete();
    tb_cnt = 0;
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
      @(posedge clock_i);
      #1;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clock_i) begin
    if (reset_i) begin
      prev_d = '0;
    end else if (log2_data_valid_o) begin
      if (log2_last_o) last_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'b0, log2_data_valid_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data", log2_data_o, e.d);
        chk("zero", {31'b0, log2_zero_o}, {31'b0, e.z});
        chk("last", {31'b0, log2_last_o}, {31'b0, e.l});
        chk("latency", 32'(cyc), 32'(e.c + 3));
      end
      prev_d = log2_data_o;
    end else begin
      chk("hold", log2_data_o, prev_d);
      chk("zero_idle", {31'b0, log2_zero_o}, 32'd0);
      chk("last_idle", {31'b0, log2_last_o}, 32'd0);
    end
  end

  initial begin
    int ls0;
    reset_i           = 1'b1;
    log2_data_i       = '0;
    log2_data_valid_i = 1'b0;
    @(posedge clock_i);
    #1;
    chk("rst_data", log2_data_o, 32'h0);
    chk("rst_valid", {31'b0, log2_data_valid_o}, 32'd0);
    chk("rst_zero", {31'b0, log2_zero_o}, 32'd0);
    chk("rst_last", {31'b0, log2_last_o}, 32'd0);
    do_reset();

    send(32'h0001_0000, 32'h0000_0000, 1'b0);
    send(32'h0002_0000, 32'h0001_0000, 1'b0);
    send(32'h0003_0000, 32'h0001_95C0, 1'b0);
    idle(2);
    send(32'h0000_0001, 32'hFFF0_0000, 1'b0);
    send(32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0);
    send(32'h0000_0000, 32'h8000_0000, 1'b1);
    send(32'h0001_0000, 32'h0000_0000, 1'b0);
    idle(1);
    drain("drain_directed");

    do_reset();
    ls0 = last_seen;
    repeat (25) sendm($urandom >> $urandom_range(0, 31));
    idle(1);
    drain("drain_run25");
    chk("last_count_25", 32'(last_seen - ls0), 32'd2);

    for (int i = 0; i < 10; i++) begin
      sendm($urandom >> $urandom_range(0, 31));
      if (i % 3 == 0) idle(2);
    end
    idle(1);
    drain("drain_gaps");

    for (int m = 0; m < 64; m++) sendm(32'(64 + m) << 10);
    idle(1);
    drain("drain_lut");

    sendm(32'h0005_0000);
    sendm(32'h0000_8000);
    reset_i           = 1'b1;
    log2_data_i       = 32'h0007_0000;
    log2_data_valid_i = 1'b1;
    exp_q.delete();
    tb_cnt = 0;
    @(posedge clock_i);
    #1;
    reset_i           = 1'b0;
    log2_data_valid_i = 1'b0;
    chk("mid_rst_data", log2_data_o, 32'h0);
    chk("mid_rst_valid", {31'b0, log2_data_valid_o}, 32'd0);
    chk("mid_rst_zero", {31'b0, log2_zero_o}, 32'd0);
    chk("mid_rst_last", {31'b0, log2_last_o}, 32'd0);
    idle(4);
    ls0 = last_seen;
    repeat (10) sendm($urandom >> $urandom_range(0, 31));
    idle(1);
    drain("drain_post_rst");
    chk("last_count_post_rst", 32'(last_seen - ls0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
